// File: rtl/spu_pkg.sv
// rtl/spu_pkg.sv - shared SPU constants, register/latency types and helpers
//
// Purpose: constants and types shared by the register scoreboard and the
// decoder. Latency constants give cycles from issue to writeback per unit.
// Ports: none (package).

package spu_pkg;

  localparam int NUM_REGS = 128;
  localparam int ADDR_W   = 7;
  localparam int LAT_W    = 3;

  typedef logic [0:ADDR_W-1] reg_addr_t;
  typedef logic [LAT_W-1:0]  lat_t;

  localparam lat_t LAT_SIMPLE_FX = 3'd2;
  localparam lat_t LAT_SHIFT     = 3'd4;
  localparam lat_t LAT_LOAD      = 3'd6;
  localparam lat_t LAT_FP        = 3'd6;
  localparam lat_t LAT_FP_DP     = 3'd7;

  // A zero latency would mean "already written"; the hardware never does
  // that, so it is promoted to a single cycle.
  function automatic lat_t eff_lat(input lat_t l);
    return (l == '0) ? lat_t'(1) : l;
  endfunction

endpackage

// File: rtl/sb_counter.sv
// rtl/sb_counter.sv - one register's remaining-latency down-counter
//
// Purpose: tracks cycles until the pending write to one register lands.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   hold         freeze the counter
//   load         an issuing instruction writes this register
//   load_val     its latency (0 is treated as 1)
//   cnt          current count
//   busy         registered flag, set while cnt != 0

module sb_counter
  import spu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic hold,
  input  logic load,
  input  lat_t load_val,
  output lat_t cnt,
  output logic busy
);

  lat_t cnt_next;

  // A new issue replaces the old count outright; the issue logic already
  // guarantees the new write does not land before the old one.
  always_comb begin
    cnt_next = cnt;
    if (!hold) begin
      if (load) begin
        cnt_next = eff_lat(load_val);
      end else if (cnt != '0) begin
        cnt_next = cnt - lat_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      busy <= (cnt_next != '0);
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - dual-pipe RAW/WAW issue scoreboard for the register file
//
// Purpose: decides each cycle whether the even and odd pipe instructions may
// issue, based on the remaining latency of in-flight writes per register.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   pipe_hold                   freeze: no issue, counters hold
//   even_valid/odd_valid        instruction present on the pipe
//   even_ra/rb/rc, even_use_*   even sources and their use flags
//   odd_ra/rb, odd_use_*        odd sources and their use flags
//   even_rt/odd_rt, *_wr        destination and write enable
//   even_lat/odd_lat            cycles from issue to writeback
//   issue_even/issue_odd        combinational issue grant
//   pair_stall                  a presented instruction was held
//   busy_vec                    per-register pending-write flags

module reg_scoreboard
  import spu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                pipe_hold,
  input  logic                even_valid,
  input  logic                odd_valid,
  input  reg_addr_t           even_ra,
  input  reg_addr_t           even_rb,
  input  reg_addr_t           even_rc,
  input  logic                even_use_a,
  input  logic                even_use_b,
  input  logic                even_use_c,
  input  reg_addr_t           odd_ra,
  input  reg_addr_t           odd_rb,
  input  logic                odd_use_a,
  input  logic                odd_use_b,
  input  reg_addr_t           even_rt,
  input  reg_addr_t           odd_rt,
  input  logic                even_wr,
  input  logic                odd_wr,
  input  lat_t                even_lat,
  input  lat_t                odd_lat,
  output logic                issue_even,
  output logic                issue_odd,
  output logic                pair_stall,
  output logic [NUM_REGS-1:0] busy_vec
);

  lat_t cnt [NUM_REGS];

  logic even_src_ok;
  logic even_waw_ok;
  logic odd_src_ok;
  logic odd_waw_ok;
  logic intra_hazard;

  // A count of 1 means the write lands this cycle and is forwarded by the
  // register file, so the reader may issue.
  always_comb begin
    even_src_ok = (!even_use_a || (cnt[even_ra] <= lat_t'(1))) &&
                  (!even_use_b || (cnt[even_rb] <= lat_t'(1))) &&
                  (!even_use_c || (cnt[even_rc] <= lat_t'(1)));
    odd_src_ok  = (!odd_use_a  || (cnt[odd_ra]  <= lat_t'(1))) &&
                  (!odd_use_b  || (cnt[odd_rb]  <= lat_t'(1)));

    // An older write still in flight must not land after this one.
    even_waw_ok = !even_wr || (cnt[even_rt] <= eff_lat(even_lat));
    odd_waw_ok  = !odd_wr  || (cnt[odd_rt]  <= eff_lat(odd_lat));

    // Odd depends on the older even instruction of the same pair; the even
    // write is not yet in the scoreboard, so odd waits a cycle and then
    // sees it like any other in-flight write.
    intra_hazard = even_valid && even_wr &&
                   ((odd_wr    && (odd_rt == even_rt)) ||
                    (odd_use_a && (odd_ra == even_rt)) ||
                    (odd_use_b && (odd_rb == even_rt)));

    issue_even = reset && even_valid && !pipe_hold && even_src_ok && even_waw_ok;
    issue_odd  = reset && odd_valid && !pipe_hold && (issue_even || !even_valid) &&
                 odd_src_ok && odd_waw_ok && !intra_hazard;

    pair_stall = (even_valid && !issue_even) || (odd_valid && !issue_odd);
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    logic ld_even;
    logic ld_odd;

    // The intra-pair rule keeps both pipes from loading the same register.
    assign ld_even = issue_even && even_wr && (even_rt == reg_addr_t'(r));
    assign ld_odd  = issue_odd  && odd_wr  && (odd_rt  == reg_addr_t'(r));

    sb_counter u_cnt (
      .clk      (clk),
      .reset    (reset),
      .hold     (pipe_hold),
      .load     (ld_even || ld_odd),
      .load_val (ld_even ? even_lat : odd_lat),
      .cnt      (cnt[r]),
      .busy     (busy_vec[r])
    );
  end

endmodule
